// File: rtl/axi4l_gpio_slave_pkg.sv
// Shared definitions for the AXI4-Lite GPIO slave: register offsets, response codes,
// the address-decode enum and the byte-strobe helper.
package axi4l_gpio_slave_pkg;

    localparam logic [7:0] OFF_DATA_OUT = 8'h00;
    localparam logic [7:0] OFF_DIR      = 8'h04;
    localparam logic [7:0] OFF_DATA_IN  = 8'h08;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_DATA_OUT,
        REG_DIR,
        REG_DATA_IN,
        REG_IRQ_EN,
        REG_IRQ_STAT,
        REG_NONE
    } gpio_reg_e;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

    // Expands a 4-lane byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi4l_gpio_slave_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the GPIO register block (slave).
interface axi4l_gpio_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4l_gpio_slave_sync.sv
// Two-flop pad-input synchroniser; also exposes the previous synchronised value so the
// parent can detect rising edges without an extra register stage.
module gpio_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_prev
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_prev = r_prev;
endmodule

// File: rtl/axi4l_gpio_slave.sv
// AXI4-Lite GPIO register block: DATA_OUT/DIR/DATA_IN, plus IRQ_EN/IRQ_STAT and a level
// interrupt on synchronised input rising edges when GPIO_IRQ_EN is defined.
module axi4l_gpio_slave
    import axi4l_gpio_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int GPIO_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4l_gpio_slave_if.slave     bus,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);
    function automatic gpio_reg_e decode(input logic [2:0] idx);
        case (idx)
            OFF_DATA_OUT[4:2]: return REG_DATA_OUT;
            OFF_DIR[4:2]:      return REG_DIR;
            OFF_DATA_IN[4:2]:  return REG_DATA_IN;
`ifdef GPIO_IRQ_EN
            OFF_IRQ_EN[4:2]:   return REG_IRQ_EN;
            OFF_IRQ_STAT[4:2]: return REG_IRQ_STAT;
`endif
            default:           return REG_NONE;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zext(input logic [GPIO_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        r[GPIO_WIDTH-1:0] = v;
        return r;
    endfunction

    function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] old_v,
                                                    input logic [DATA_WIDTH-1:0] wdata,
                                                    input logic [DATA_WIDTH-1:0] mask);
        logic [DATA_WIDTH-1:0] full;
        full = (zext(old_v) & ~mask) | (wdata & mask);
        return full[GPIO_WIDTH-1:0];
    endfunction

    logic [GPIO_WIDTH-1:0] w_sync;
    logic [GPIO_WIDTH-1:0] w_sync_prev;

    gpio_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (gpio_in),
        .o_sync  (w_sync),
        .o_prev  (w_sync_prev)
    );

    logic                  r_aw_held;
    logic                  r_w_held;
    logic [2:0]            r_awidx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [GPIO_WIDTH-1:0] r_dout;
    logic [GPIO_WIDTH-1:0] r_dir;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wr_go;
    gpio_reg_e             w_wr_reg;
    logic [DATA_WIDTH-1:0] w_wmask;

    assign w_awready = rst & ~r_aw_held & ~r_bvalid;
    assign w_wready  = rst & ~r_w_held & ~r_bvalid;
    assign w_aw_hs   = bus.AWVALID & w_awready;
    assign w_w_hs    = bus.WVALID & w_wready;
    assign w_wr_go   = r_aw_held & r_w_held;
    assign w_wr_reg  = decode(r_awidx);
    assign w_wmask   = strb_mask(r_wstrb);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_dout    <= '0;
            r_dir     <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awidx   <= bus.AWADDR[4:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= bus.WDATA;
                r_wstrb  <= bus.WSTRB;
            end
            if (w_wr_go) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= (w_wr_reg == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
                if (w_wr_reg == REG_DATA_OUT) r_dout <= merge(r_dout, r_wdata, w_wmask);
                if (w_wr_reg == REG_DIR)      r_dir  <= merge(r_dir, r_wdata, w_wmask);
            end else if (r_bvalid && bus.BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] r_irq_en;
    logic [GPIO_WIDTH-1:0] r_irq_stat;
    logic                  r_irq;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_stat_clr;
    logic [DATA_WIDTH-1:0] w_clr_full;

    assign w_rise     = w_sync & ~w_sync_prev;
    assign w_clr_full = r_wdata & w_wmask;
    assign w_stat_clr = (w_wr_go && w_wr_reg == REG_IRQ_STAT) ? w_clr_full[GPIO_WIDTH-1:0] : '0;

    // Set is OR-ed in after the clear so a coincident edge keeps its status bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_irq_en   <= '0;
            r_irq_stat <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_go && w_wr_reg == REG_IRQ_EN) r_irq_en <= merge(r_irq_en, r_wdata, w_wmask);
            r_irq_stat <= (r_irq_stat & ~w_stat_clr) | w_rise;
            r_irq      <= |(r_irq_stat & r_irq_en);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    rd_state_e             r_rd_state;
    rd_state_e             w_rd_state_nxt;
    logic                  w_arready;
    logic                  w_ar_hs;
    gpio_reg_e             w_ar_reg;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_rd_resp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    assign w_ar_hs  = bus.ARVALID & w_arready;
    assign w_ar_reg = decode(bus.ARADDR[4:2]);

    always_ff @(posedge clk) begin
        if (!rst) r_rd_state <= RD_IDLE;
        else      r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready      = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                w_arready = rst;
                if (w_ar_hs) w_rd_state_nxt = RD_RESP;
            end
            RD_RESP: begin
                if (bus.RREADY) w_rd_state_nxt = RD_IDLE;
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_ar_reg)
            REG_DATA_OUT: w_rd_data = zext(r_dout);
            REG_DIR:      w_rd_data = zext(r_dir);
            REG_DATA_IN:  w_rd_data = zext(w_sync);
`ifdef GPIO_IRQ_EN
            REG_IRQ_EN:   w_rd_data = zext(r_irq_en);
            REG_IRQ_STAT: w_rd_data = zext(r_irq_stat);
`endif
            default:      w_rd_resp = RESP_SLVERR;
        endcase
    end

    // Read data is sampled at the AR handshake, so a same-edge write is not yet visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

    assign bus.AWREADY = w_awready;
    assign bus.WREADY  = w_wready;
    assign bus.BVALID  = r_bvalid;
    assign bus.BRESP   = r_bresp;
    assign bus.ARREADY = w_arready;
    assign bus.RVALID  = (r_rd_state == RD_RESP);
    assign bus.RDATA   = r_rdata;
    assign bus.RRESP   = r_rresp;
    assign gpio_out    = r_dout;
    assign gpio_oe     = r_dir;

    logic w_unused_ok;
`ifdef GPIO_IRQ_EN
    assign w_unused_ok = &{1'b0, bus.AWADDR[ADDR_WIDTH-1:5], bus.AWADDR[1:0],
                           bus.ARADDR[ADDR_WIDTH-1:5], bus.ARADDR[1:0]};
`else
    assign w_unused_ok = &{1'b0, bus.AWADDR[ADDR_WIDTH-1:5], bus.AWADDR[1:0],
                           bus.ARADDR[ADDR_WIDTH-1:5], bus.ARADDR[1:0], w_sync_prev};
`endif
endmodule
